// File: rtl/spart_pkg.sv
// Shared SPART definitions: line-state encoding and frame geometry.
// Used by spart_tx today and by spart_rx later.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } spart_state_t;

  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;
  localparam int BIT_CNT_W  = $clog2(DATA_BITS);

endpackage

// File: rtl/spart_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible on dout
// without a read latency so the consumer can load it on the pop edge.
module spart_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // full is taken from the pre-edge count, so a same-cycle pop never frees a slot for a push
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: buffers bytes and sends 8N1 frames, LSB first,
// with the bit period latched from baud_div at each frame start.
module spart_tx
  import spart_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int DIV_W = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic [DIV_W-1:0] baud_div,
  output logic             txd,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             ovf
);

  spart_state_t           state, state_d;
  logic [DIV_W-1:0]       baud_cnt;
  logic [DIV_W-1:0]       div_q;
  logic [DATA_BITS-1:0]   shift;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [DATA_BITS-1:0]   head;
  logic                   pop;
  logic                   bit_done;
  logic                   txd_d;

  spart_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bit_done = (baud_cnt == '0);
  assign busy     = (state != IDLE);

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    txd_d   = txd;
    unique case (state)
      IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          txd_d   = shift[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            txd_d = shift[1];
          end
        end
      end
      STOP: begin
        // chain straight into the next start bit when a byte is waiting
        if (bit_done) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_d;
      txd   <= txd_d;
      ovf   <= wr_en && full;
      if (pop)                  baud_cnt <= baud_div;
      else if (state != IDLE)   baud_cnt <= bit_done ? div_q : baud_cnt - 1'b1;
      if (pop)                          bit_cnt <= '0;
      else if (state == DATA && bit_done) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= head;
      div_q <= baud_div;
    end else if (state == DATA && bit_done) begin
      shift <= shift >> 1;
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: frame-timeline model compared every cycle,
// plus literal line patterns and durations for the key scenarios.
module tb_spart_tx;
  import spart_pkg::*;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic [DIV_W-1:0] baud_div;
  logic             txd;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  spart_tx #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .baud_div (baud_div),
    .txd      (txd),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue plus the timeline of the frame on the wire.
  byte unsigned m_q[$];
  byte unsigned m_b;
  bit           m_active = 1'b0;
  bit           m_ovf = 1'b0;
  bit           m_was_full;
  int           m_t = 0;
  int           m_div = 0;
  logic [9:0]   m_frame = '1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
      m_t      = 0;
    end else begin
      m_was_full = (m_q.size() == DEPTH);
      m_ovf      = wr_en && m_was_full;
      if (m_active) begin
        m_t++;
        if (m_t == FRAME_BITS * (m_div + 1)) m_active = 1'b0;
      end
      if (!m_active && m_q.size() > 0) begin
        m_b      = m_q.pop_front();
        m_frame  = {1'b1, m_b, 1'b0};
        m_div    = int'(baud_div);
        m_t      = 0;
        m_active = 1'b1;
      end
      if (wr_en && !m_was_full) m_q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_txd",   32'(txd),   32'(m_active ? m_frame[m_t / (m_div + 1)] : 1'b1));
      check("m_busy",  32'(busy),  32'(m_active));
      check("m_count", 32'(count), 32'(m_q.size()));
      check("m_full",  32'(full),  32'(m_q.size() == DEPTH));
      check("m_empty", 32'(empty), 32'(m_q.size() == 0));
      check("m_ovf",   32'(ovf),   32'(m_ovf));
    end
  end

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (!(empty && !busy) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(empty && !busy), 32'd1);
  endtask

  task automatic measure_frame(output int len, input int change_at, input logic [DIV_W-1:0] new_div);
    len = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy) begin
        len++;
        if (len == change_at) baud_div = new_div;
      end else if (len > 0) begin
        break;
      end
    end
  endtask

  int seq_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int seq_bb [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    int busy_cycles;
    int len;
    int lows;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    baud_div = 16'd3;
    repeat (3) @(negedge clk);
    check("rst_txd",   32'(txd),   32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single 0xA5 frame, 4-cycle bits
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("a5_txd", 32'(txd), 32'(seq_a5[i / 4]));
      if (busy) busy_cycles++;
    end
    @(negedge clk);
    check("a5_busy_len",  32'(busy_cycles), 32'd40);
    check("a5_busy_fall", 32'(busy), 32'd0);
    wait_idle(100);

    // overflow: six back-to-back writes from idle
    baud_div = 16'd15;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 5) begin
        check("ovf_full_after5",  32'(full),  32'd1);
        check("ovf_count_after5", 32'(count), 32'd4);
        check("ovf_none_yet",     32'(ovf),   32'd0);
      end
      wr_en = 1'b1; wr_data = 8'(8'h10 + k);
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_pulse",      32'(ovf),   32'd1);
    check("ovf_count",      32'(count), 32'd4);
    @(negedge clk);
    check("ovf_pulse_end",  32'(ovf),   32'd0);
    wait_idle(1200);

    // back-to-back frames at one cycle per bit
    baud_div = 16'd0;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h00;
    @(negedge clk);
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    check("bb_txd", 32'(txd), 32'(seq_bb[0]));
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      check("bb_txd", 32'(txd), 32'(seq_bb[i]));
    end
    @(negedge clk);
    check("bb_idle_after", 32'(txd), 32'd1);
    wait_idle(50);

    // divisor change in the middle of the data bits
    baud_div = 16'd1;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    measure_frame(len, 6, 16'd7);
    check("div_frame1_len", 32'(len), 32'd20);
    wait_idle(50);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    measure_frame(len, 0, 16'd7);
    check("div_frame2_len", 32'(len), 32'd80);
    wait_idle(200);

    // asynchronous reset during the data bits with two bytes queued
    baud_div = 16'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'(8'hC0 + k);
    end
    @(negedge clk);
    wr_en = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_count_before", 32'(count), 32'd2);
    check("mid_busy_before",  32'(busy),  32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_txd",   32'(txd),   32'd1);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_busy",  32'(busy),  32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!txd || busy) lows++;
    end
    check("post_rst_idle_line", 32'(lows),  32'd0);
    check("post_rst_empty",     32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
